// File: rtl/dig_ct_pkg.sv
// Shared types, sizes and golden model for the 5-in/3-out circuit stimulus checker.
package dig_ct_pkg;

  localparam int N_VEC = 32;
  localparam int VEC_W = 5;
  localparam int OUT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    FINISH
  } state_t;

  // One in-flight launched vector and the response it must produce.
  typedef struct packed {
    logic             vld;
    logic [VEC_W-1:0] vec;
    logic [OUT_W-1:0] exp_out;
  } exp_ent_t;

  // bit0=OUT1, bit1=OUT2, bit2=OUT3
  function automatic logic [OUT_W-1:0] dig_ct_golden(input logic [VEC_W-1:0] v);
    logic e1, e2, e3;
    e1 = ~(~(v[0] | v[1]) & v[2]);
    e2 = ~(v[1] & v[2]);
    e3 = ~v[3] | v[2] | v[4];
    return {e3, e2, e1};
  endfunction

endpackage

// File: rtl/dig_ct_stim_chk_if.sv
// Vector/response link between the checker (master) and the circuit under test (slave).
interface dig_ct_stim_chk_if;
  import dig_ct_pkg::*;

  logic [VEC_W-1:0] DUT_IN;
  logic [OUT_W-1:0] DUT_OUT;

  modport master (output DUT_IN, input DUT_OUT);
  modport slave  (input DUT_IN, output DUT_OUT);
endinterface

// File: rtl/dig_ct_exp_pipe.sv
// LATENCY-deep shift register carrying {valid, vec, expected} alongside the circuit's own pipeline.
module dig_ct_exp_pipe
  import dig_ct_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic     CLK,
  input  logic     RST,
  input  exp_ent_t in_ent,
  output exp_ent_t out_ent
);

  exp_ent_t [LATENCY:1] stg_d, stg_q;

  always_comb begin
    stg_d    = stg_q;
    stg_d[1] = in_ent;
    for (int i = 2; i <= LATENCY; i++) stg_d[i] = stg_q[i-1];
  end

  always_ff @(posedge CLK) begin
    if (!RST) stg_q <= '0;
    else      stg_q <= stg_d;
  end

  assign out_ent = stg_q[LATENCY];

endmodule

// File: rtl/dig_ct_stim_chk.sv
// Sweeps all 32 input vectors into the circuit and scores the registered responses
// against the golden model, reporting pass/fail, error count and first failing vector.
module dig_ct_stim_chk
  import dig_ct_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ERR_W   = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  dig_ct_stim_chk_if.master    circ,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [ERR_W-1:0]     ERR_CNT,
  output logic [VEC_W-1:0]     FIRST_ERR_VEC,
  output logic                 FIRST_ERR_VLD
);

  localparam int DCW = 3;

  state_t           state_d, state_q;
  logic [VEC_W-1:0] vec_cnt_d, vec_cnt_q;
  logic [VEC_W-1:0] dut_in_d, dut_in_q;
  logic             lch_vld_d, lch_vld_q;
  logic [DCW-1:0]   drain_cnt_d, drain_cnt_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             pass_d, pass_q;
  logic [ERR_W-1:0] err_cnt_d, err_cnt_q;
  logic [VEC_W-1:0] fev_d, fev_q;
  logic             fvld_d, fvld_q;

  exp_ent_t lch_ent, chk_ent;
  logic     mismatch;

  // Stage 0 is the launch register itself, so the circuit's LATENCY registers
  // line up with the LATENCY stages of the expected-value pipe.
  assign lch_ent = {lch_vld_q, dut_in_q, dig_ct_golden(dut_in_q)};

  dig_ct_exp_pipe #(.LATENCY(LATENCY)) u_exp_pipe (
    .CLK     (CLK),
    .RST     (RST),
    .in_ent  (lch_ent),
    .out_ent (chk_ent)
  );

  // Case inequality so X/Z on the response is scored as a miss.
  assign mismatch = chk_ent.vld && (circ.DUT_OUT !== chk_ent.exp_out);

  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    dut_in_d    = dut_in_q;
    lch_vld_d   = 1'b0;
    drain_cnt_d = drain_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fev_d       = fev_q;
    fvld_d      = fvld_q;

    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (!fvld_q) begin
        fev_d  = chk_ent.vec;
        fvld_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = DRIVE;
          vec_cnt_d = '0;
          err_cnt_d = '0;
          fev_d     = '0;
          fvld_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      DRIVE: begin
        dut_in_d  = vec_cnt_q;
        lch_vld_d = 1'b1;
        vec_cnt_d = vec_cnt_q + 1'b1;
        if (vec_cnt_d == '0) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        // The last compare lands on this same edge, so PASS uses the next count.
        if (drain_cnt_q == DCW'(LATENCY)) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_cnt_d == '0);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      vec_cnt_q   <= '0;
      dut_in_q    <= '0;
      lch_vld_q   <= 1'b0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fev_q       <= '0;
      fvld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_cnt_q   <= vec_cnt_d;
      dut_in_q    <= dut_in_d;
      lch_vld_q   <= lch_vld_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fev_q       <= fev_d;
      fvld_q      <= fvld_d;
    end
  end

  assign circ.DUT_IN   = dut_in_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign PASS          = pass_q;
  assign ERR_CNT       = err_cnt_q;
  assign FIRST_ERR_VEC = fev_q;
  assign FIRST_ERR_VLD = fvld_q;

endmodule

// File: tb/tb_dig_ct_stim_chk.sv
// Directed bench: a 1-stage and a 3-stage model circuit with injectable stuck-at faults.
module tb_dig_ct_stim_chk;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic       busy1, done1, pass1, fvld1;
  logic       busy3, done3, pass3, fvld3;
  logic [5:0] err1, err3;
  logic [4:0] fev1, fev3;
  logic [2:0] sa0 = 3'b000, sa1 = 3'b000;
  logic [2:0] p3a, p3b;
  int         n_chk = 0, n_pass = 0;

  always #5 CLK = ~CLK;

  dig_ct_stim_chk_if if1 ();
  dig_ct_stim_chk_if if3 ();

  dig_ct_stim_chk #(.LATENCY(1), .ERR_W(6)) u_dut1 (
    .CLK(CLK), .RST(RST), .START(start1), .circ(if1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1),
    .FIRST_ERR_VEC(fev1), .FIRST_ERR_VLD(fvld1)
  );

  dig_ct_stim_chk #(.LATENCY(3), .ERR_W(6)) u_dut3 (
    .CLK(CLK), .RST(RST), .START(start3), .circ(if3),
    .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3),
    .FIRST_ERR_VEC(fev3), .FIRST_ERR_VLD(fvld3)
  );

  function automatic logic [2:0] ref_out(input logic [4:0] v);
    logic o1, o2, o3;
    o1 = ~(~(v[0] | v[1]) & v[2]);
    o2 = ~(v[1] & v[2]);
    o3 = ~v[3] | v[2] | v[4];
    return {o3, o2, o1};
  endfunction

  // Circuit models: one register (with faults) and three registers (clean).
  always @(posedge CLK) if1.DUT_OUT <= (ref_out(if1.DUT_IN) & ~sa0) | sa1;
  always @(posedge CLK) begin
    p3a         <= ref_out(if3.DUT_IN);
    p3b         <= p3a;
    if3.DUT_OUT <= p3b;
  end

  // Runs one sweep for 60 cycles; returns DONE cycle, DONE count and BUSY cycles.
  task automatic run_sweep(input bit sel3, input int xs_a, input int xs_b,
                           output int done_cyc, output int n_done, output int busy_cyc);
    done_cyc = -1; n_done = 0; busy_cyc = 0;
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge CLK); #1;
    start1 = 1'b0; start3 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == xs_a || c == xs_b) begin
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
      end
      if (sel3 ? busy3 : busy1) busy_cyc++;
      @(posedge CLK); #1;
      start1 = 1'b0; start3 = 1'b0;
      if (sel3 ? done3 : done1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_chk++; if ({busy1, done1, pass1, fvld1} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy1, done1, pass1, fvld1}); else n_pass++;
    n_chk++; if (err1 !== 6'd0) $display("FAIL reset_err got %0d want 0", err1); else n_pass++;
    n_chk++; if (if1.DUT_IN !== 5'd0) $display("FAIL reset_dut_in got %0d want 0", if1.DUT_IN); else n_pass++;
    n_chk++; if ({busy3, done3, pass3, err3} !== 9'd0) $display("FAIL reset_l3 got %h want 0", {busy3, done3, pass3, err3}); else n_pass++;
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_clean();
    int dc, nd, bc;
    sa0 = 3'b000; sa1 = 3'b000;
    run_sweep(1'b0, 0, 0, dc, nd, bc);
    n_chk++; if (dc !== 34) $display("FAIL clean_done_cycle got %0d want 34", dc); else n_pass++;
    n_chk++; if (nd !== 1) $display("FAIL clean_done_count got %0d want 1", nd); else n_pass++;
    n_chk++; if (bc !== 34) $display("FAIL clean_busy_cycles got %0d want 34", bc); else n_pass++;
    n_chk++; if (pass1 !== 1'b1) $display("FAIL clean_pass got %b want 1", pass1); else n_pass++;
    n_chk++; if (err1 !== 6'd0) $display("FAIL clean_err got %0d want 0", err1); else n_pass++;
    n_chk++; if (fvld1 !== 1'b0) $display("FAIL clean_fvld got %b want 0", fvld1); else n_pass++;
    n_chk++; if (if1.DUT_IN !== 5'd31) $display("FAIL clean_dut_in_hold got %0d want 31", if1.DUT_IN); else n_pass++;
  endtask

  task automatic test_out2_sa0();
    int dc, nd, bc;
    sa0 = 3'b010; sa1 = 3'b000;
    run_sweep(1'b0, 0, 0, dc, nd, bc);
    n_chk++; if (err1 !== 6'd24) $display("FAIL out2_sa0_err got %0d want 24", err1); else n_pass++;
    n_chk++; if ({fvld1, fev1} !== {1'b1, 5'd0}) $display("FAIL out2_sa0_first got %b/%0d want 1/0", fvld1, fev1); else n_pass++;
    n_chk++; if (pass1 !== 1'b0) $display("FAIL out2_sa0_pass got %b want 0", pass1); else n_pass++;
  endtask

  task automatic test_out3_sa1();
    int dc, nd, bc;
    sa0 = 3'b000; sa1 = 3'b100;
    run_sweep(1'b0, 0, 0, dc, nd, bc);
    n_chk++; if (err1 !== 6'd4) $display("FAIL out3_sa1_err got %0d want 4", err1); else n_pass++;
    n_chk++; if ({fvld1, fev1} !== {1'b1, 5'd8}) $display("FAIL out3_sa1_first got %b/%0d want 1/8", fvld1, fev1); else n_pass++;
    n_chk++; if (pass1 !== 1'b0) $display("FAIL out3_sa1_pass got %b want 0", pass1); else n_pass++;
  endtask

  task automatic test_out1_sa1_rerun();
    int dc, nd, bc;
    sa0 = 3'b000; sa1 = 3'b001;
    run_sweep(1'b0, 0, 0, dc, nd, bc);
    n_chk++; if (err1 !== 6'd4) $display("FAIL out1_sa1_err got %0d want 4", err1); else n_pass++;
    n_chk++; if ({fvld1, fev1} !== {1'b1, 5'd4}) $display("FAIL out1_sa1_first got %b/%0d want 1/4", fvld1, fev1); else n_pass++;
    sa1 = 3'b000;
    run_sweep(1'b0, 0, 0, dc, nd, bc);
    n_chk++; if (err1 !== 6'd0) $display("FAIL rerun_err got %0d want 0", err1); else n_pass++;
    n_chk++; if ({pass1, fvld1} !== 2'b10) $display("FAIL rerun_pass_fvld got %b want 10", {pass1, fvld1}); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    int dc, nd, bc, seen;
    sa0 = 3'b010; sa1 = 3'b000;
    start1 = 1'b1;
    @(posedge CLK); #1;
    start1 = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    // Vectors 0..5 mismatch on OUT2, vector 6 matches.
    n_chk++; if (err1 !== 6'd6) $display("FAIL mid_err_before_reset got %0d want 6", err1); else n_pass++;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    n_chk++; if ({busy1, done1, pass1, fvld1} !== 4'b0) $display("FAIL mid_reset_flags got %b want 0000", {busy1, done1, pass1, fvld1}); else n_pass++;
    n_chk++; if ({err1, fev1, if1.DUT_IN} !== 16'd0) $display("FAIL mid_reset_vals got %h want 0", {err1, fev1, if1.DUT_IN}); else n_pass++;
    sa0 = 3'b000;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge CLK); #1;
      if (done1 || busy1) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL mid_reset_no_done got %0d active cycles want 0", seen); else n_pass++;
    run_sweep(1'b0, 0, 0, dc, nd, bc);
    n_chk++; if (dc !== 34 || nd !== 1) $display("FAIL mid_restart_done got cyc %0d cnt %0d want 34/1", dc, nd); else n_pass++;
    n_chk++; if ({pass1, err1} !== {1'b1, 6'd0}) $display("FAIL mid_restart_pass got %b/%0d want 1/0", pass1, err1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dc, nd, bc;
    sa0 = 3'b000; sa1 = 3'b000;
    run_sweep(1'b0, 5, 20, dc, nd, bc);
    n_chk++; if (nd !== 1) $display("FAIL b2b_done_count got %0d want 1", nd); else n_pass++;
    n_chk++; if (dc !== 34) $display("FAIL b2b_done_cycle got %0d want 34", dc); else n_pass++;
    n_chk++; if (pass1 !== 1'b1) $display("FAIL b2b_pass got %b want 1", pass1); else n_pass++;
  endtask

  task automatic test_latency3();
    int dc, nd, bc;
    run_sweep(1'b1, 0, 0, dc, nd, bc);
    n_chk++; if (dc !== 36) $display("FAIL l3_done_cycle got %0d want 36", dc); else n_pass++;
    n_chk++; if (bc !== 36) $display("FAIL l3_busy_cycles got %0d want 36", bc); else n_pass++;
    n_chk++; if ({pass3, err3, fvld3} !== {1'b1, 6'd0, 1'b0}) $display("FAIL l3_result got %b/%0d/%b want 1/0/0", pass3, err3, fvld3); else n_pass++;
    n_chk++; if (nd !== 1) $display("FAIL l3_done_count got %0d want 1", nd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_out2_sa0();
    test_out3_sa1();
    test_out1_sa1_rerun();
    test_reset_mid_sweep();
    test_back_to_back();
    test_latency3();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
